// File: rtl/envelope_pkg.sv
// Shared types and constants for the ADSR envelope generator.
package envelope_pkg;

    typedef enum logic [2:0] {
        ENV_OFF     = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    // Divisor exponent for the optional exponential release tail (acc >> 5).
    localparam int EXP_SHIFT = 5;

    function automatic logic [63:0] acc_max(input int bits);
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/env_sat_step.sv
// Saturating add/sub of an operand into an accumulator; limit flags a clamp or an exact hit.
// Purely combinational, no backpressure.
module env_sat_step #(
    parameter int ACC_BITS = 16,
    parameter int OP_BITS  = 16
) (
    input  logic [ACC_BITS-1:0] acc,
    input  logic [OP_BITS-1:0]  op,
    input  logic                sub,
    output logic [ACC_BITS-1:0] result,
    output logic                limit
);
    import envelope_pkg::*;

    // One guard bit above the wider operand catches both carry-out and borrow.
    localparam int W = ((OP_BITS > ACC_BITS) ? OP_BITS : ACC_BITS) + 1;
    localparam logic [W-1:0]        MAX_X = W'(acc_max(ACC_BITS));
    localparam logic [ACC_BITS-1:0] MAX   = ACC_BITS'(acc_max(ACC_BITS));

    logic [W-1:0] acc_x;
    logic [W-1:0] op_x;
    logic [W-1:0] res_x;

    assign acc_x = W'(acc);
    assign op_x  = W'(op);
    assign res_x = sub ? (acc_x - op_x) : (acc_x + op_x);

    always_comb begin
        result = '0;
        limit  = 1'b0;
        if (sub) begin
            limit  = res_x[W-1] || (res_x == '0);
            result = res_x[W-1] ? '0 : res_x[ACC_BITS-1:0];
        end else begin
            limit  = (res_x >= MAX_X);
            result = limit ? MAX : res_x[ACC_BITS-1:0];
        end
    end

endmodule

// File: rtl/envelope_generator.sv
// ADSR envelope: gate-driven five-state ramp, advances one step per tick; amplitude valid the clk after a tick.
// No backpressure. `ENVELOPE_EXP_RELEASE_EN selects an exponential-ish release tail instead of linear.
module envelope_generator #(
    parameter int ACC_BITS       = 16,
    parameter int RATE_BITS      = 16,
    parameter int AMPLITUDE_BITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      gate,
    input  logic [RATE_BITS-1:0]      attack_inc,
    input  logic [RATE_BITS-1:0]      decay_inc,
    input  logic [AMPLITUDE_BITS-1:0] sustain,
    input  logic [RATE_BITS-1:0]      release_inc,
    output logic [AMPLITUDE_BITS-1:0] amplitude,
    output logic                      busy
);
    import envelope_pkg::*;

    localparam logic [ACC_BITS-1:0] MAX = ACC_BITS'(acc_max(ACC_BITS));
`ifdef ENVELOPE_EXP_RELEASE_EN
    localparam int OP_BITS = ACC_BITS + 1;
`else
    localparam int OP_BITS = RATE_BITS;
`endif

    env_state_t            state;
    env_state_t            eff_state;
    logic [ACC_BITS-1:0]   acc;
    logic [ACC_BITS-1:0]   sus_acc;
    logic [ACC_BITS-1:0]   step_res;
    logic [OP_BITS-1:0]    step_op;
    logic                  step_sub;
    logic                  step_limit;
    logic                  gate_q;
    logic                  rise;

    assign sus_acc = ACC_BITS'(sustain) << (ACC_BITS - AMPLITUDE_BITS);
    assign rise    = gate && !gate_q;
    // A rising gate performs its first attack step on the same tick, from the current level.
    assign eff_state = rise ? ENV_ATTACK : state;

    always_comb begin
        step_sub = 1'b1;
        step_op  = '0;
        case (eff_state)
            ENV_ATTACK: begin
                step_sub = 1'b0;
                step_op  = OP_BITS'(attack_inc);
            end
            ENV_DECAY:   step_op = OP_BITS'(decay_inc);
`ifdef ENVELOPE_EXP_RELEASE_EN
            ENV_RELEASE: step_op = OP_BITS'(acc >> EXP_SHIFT) + OP_BITS'(release_inc);
`else
            ENV_RELEASE: step_op = OP_BITS'(release_inc);
`endif
            default: ;
        endcase
    end

    env_sat_step #(
        .ACC_BITS (ACC_BITS),
        .OP_BITS  (OP_BITS)
    ) u_step (
        .acc    (acc),
        .op     (step_op),
        .sub    (step_sub),
        .result (step_res),
        .limit  (step_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ENV_OFF;
            acc    <= '0;
            gate_q <= 1'b0;
        end else if (tick) begin
            gate_q <= gate;
            if (!gate && (state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})) begin
                state <= ENV_RELEASE;
            end else begin
                case (eff_state)
                    ENV_OFF: acc <= '0;
                    ENV_ATTACK: begin
                        state <= ENV_ATTACK;
                        if (attack_inc == '0) begin
                            acc   <= MAX;
                            state <= ENV_DECAY;
                        end else begin
                            acc <= step_res;
                            if (step_limit) state <= ENV_DECAY;
                        end
                    end
                    ENV_DECAY: begin
                        // An underflowing step saturates to 0, which always lands at or below sustain.
                        if (decay_inc == '0 || step_res <= sus_acc) begin
                            acc   <= sus_acc;
                            state <= ENV_SUSTAIN;
                        end else begin
                            acc <= step_res;
                        end
                    end
                    ENV_SUSTAIN: acc <= sus_acc;
                    ENV_RELEASE: begin
                        if (release_inc == '0) begin
                            acc   <= '0;
                            state <= ENV_OFF;
                        end else begin
                            acc <= step_res;
                            if (step_limit) state <= ENV_OFF;
                        end
                    end
                    default: begin
                        acc   <= '0;
                        state <= ENV_OFF;
                    end
                endcase
            end
        end
    end

    assign amplitude = acc[ACC_BITS-1 -: AMPLITUDE_BITS];
    assign busy      = (state != ENV_OFF);

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboard bench for envelope_generator: a behavioural ADSR model queues the expected output per clock.
module tb_envelope_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        gate;
    logic [15:0] attack_inc;
    logic [15:0] decay_inc;
    logic [15:0] release_inc;
    logic [7:0]  sustain;
    logic [7:0]  amplitude;
    logic        busy;

    envelope_generator #(
        .ACC_BITS       (16),
        .RATE_BITS      (16),
        .AMPLITUDE_BITS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .gate        (gate),
        .attack_inc  (attack_inc),
        .decay_inc   (decay_inc),
        .sustain     (sustain),
        .release_inc (release_inc),
        .amplitude   (amplitude),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    localparam int M_OFF = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;
    localparam int FULL  = 65535;

    int          m_acc = 0;
    int          m_st  = M_OFF;
    bit          m_gq  = 1'b0;
    logic [8:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [7:0] exp_amp, input logic exp_busy);
        checks++;
        if (amplitude !== exp_amp || busy !== exp_busy) begin
            errors++;
            $display("FAIL %s: amplitude=%h busy=%b, expected amplitude=%h busy=%b at %0t",
                     name, amplitude, busy, exp_amp, exp_busy, $time);
        end
    endtask

    // Reference envelope: plain integer arithmetic on the level, applied to the inputs of this clock.
    task automatic model_cycle();
        int  nxt;
        int  lvl;
        int  dec;
        bit  act;
        if (rst) begin
            m_acc = 0;
            m_st  = M_OFF;
            m_gq  = 1'b0;
        end else if (tick) begin
            act = 1'b1;
            if (gate && !m_gq) begin
                m_st = M_ATT;
            end else if (!gate && (m_st inside {M_ATT, M_DEC, M_SUS})) begin
                m_st = M_REL;
                act  = 1'b0;
            end
            lvl = int'(sustain) * 256;
            if (act) begin
                case (m_st)
                    M_OFF: m_acc = 0;
                    M_ATT: begin
                        nxt = m_acc + int'(attack_inc);
                        if (attack_inc == 0 || nxt >= FULL) begin
                            m_acc = FULL;
                            m_st  = M_DEC;
                        end else m_acc = nxt;
                    end
                    M_DEC: begin
                        nxt = m_acc - int'(decay_inc);
                        if (decay_inc == 0 || nxt <= lvl) begin
                            m_acc = lvl;
                            m_st  = M_SUS;
                        end else m_acc = nxt;
                    end
                    M_SUS: m_acc = lvl;
                    default: begin
                        dec = int'(release_inc);
`ifdef ENVELOPE_EXP_RELEASE_EN
                        dec = dec + m_acc / 32;
`endif
                        if (release_inc == 0 || m_acc - dec <= 0) begin
                            m_acc = 0;
                            m_st  = M_OFF;
                        end else m_acc = m_acc - dec;
                    end
                endcase
            end
            m_gq = gate;
        end
        exp_q.push_back({8'(m_acc / 256), (m_st != M_OFF)});
    endtask

    task automatic drive(input bit t, input bit g, input bit r);
        @(negedge clk);
        tick = t;
        gate = g;
        rst  = r;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick4(input bit g);
        drive(1'b1, g, 1'b0);
        repeat (3) drive(1'b0, g, 1'b0);
    endtask

    function automatic logic [15:0] rnd_rate();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(1, 255));
            2:       return 16'($urandom_range(256, 4095));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // Monitor: every clock that stimulus was applied has one queued expectation.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", e[8:1], e[0]);
            end
        end
    end

    initial begin
        bit g;
        rst = 1'b1; tick = 1'b0; gate = 1'b0;
        attack_inc = '0; decay_inc = '0; release_inc = '0; sustain = '0;
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        check("reset_state", 8'h00, 1'b0);

        // Full ADSR at one tick per four clocks
        attack_inc = 16'h1000; decay_inc = 16'h0800; sustain = 8'h80; release_inc = 16'h0100;
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick4(1'b1);
            if (i == 15) check("attack_15", 8'hF0, 1'b1);
        end
        check("attack_peak", 8'hFF, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            tick4(1'b1);
            if (i == 15) check("decay_15", 8'h87, 1'b1);
        end
        check("decay_clamp", 8'h80, 1'b1);
        repeat (4) tick4(1'b1);
        check("sustain_hold", 8'h80, 1'b1);

        // Gate glitch between ticks is invisible; sustain change waits for a tick
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        tick4(1'b1);
        check("gate_glitch", 8'h80, 1'b1);
        sustain = 8'h20;
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        check("sustain_pending", 8'h80, 1'b1);
        tick4(1'b1);
        check("sustain_live", 8'h20, 1'b1);
        sustain = 8'h80;
        tick4(1'b1);
        check("sustain_restore", 8'h80, 1'b1);

        tick4(1'b0);
        check("release_edge", 8'h80, 1'b1);
        for (int i = 1; i <= 127; i++) tick4(1'b0);
        check("release_127", 8'h01, 1'b1);
        tick4(1'b0);
        check("release_end", 8'h00, 1'b0);

        // Reset in the middle of a release
        attack_inc = 16'h4000;
        tick4(1'b1);
        tick4(1'b0);
        check("rst_pre", 8'h40, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check("rst_mid_release", 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Instant rates
        attack_inc = '0; decay_inc = '0; release_inc = '0; sustain = 8'h40;
        tick4(1'b1);
        check("instant_attack", 8'hFF, 1'b1);
        tick4(1'b1);
        check("instant_decay", 8'h40, 1'b1);
        tick4(1'b0);
        check("instant_rel_edge", 8'h40, 1'b1);
        tick4(1'b0);
        check("instant_release", 8'h00, 1'b0);

        // Retrigger from the middle of a release keeps the level
        attack_inc = 16'h6000; release_inc = 16'h0100; sustain = 8'h80;
        tick4(1'b1);
        tick4(1'b0);
        repeat (3) tick4(1'b0);
        check("retrig_pre", 8'h5D, 1'b1);
        attack_inc = 16'h0100;
        tick4(1'b1);
        check("retrigger", 8'h5E, 1'b1);
        release_inc = '0;
        tick4(1'b0);
        tick4(1'b0);

        // Release shape from 0x8000 with release_inc=1
        attack_inc = 16'h8000; release_inc = 16'h0001;
        tick4(1'b1);
        tick4(1'b0);
        tick4(1'b0);
`ifdef ENVELOPE_EXP_RELEASE_EN
        check("release_first_step", 8'h7B, 1'b1);
`else
        check("release_first_step", 8'h7F, 1'b1);
`endif
        release_inc = 16'h0040;
        for (int i = 0; i < 2000 && busy; i++) drive(1'b1, 1'b0, 1'b0);
        check("release_to_off", 8'h00, 1'b0);

        // Randomised traffic against the model
        g = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) attack_inc  = rnd_rate();
            if ($urandom_range(0, 15) == 0) decay_inc   = rnd_rate();
            if ($urandom_range(0, 15) == 0) release_inc = rnd_rate();
            if ($urandom_range(0, 40) == 0) sustain     = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0)  g = ~g;
            drive($urandom_range(0, 2) == 0, g, $urandom_range(0, 699) == 0);
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
